// File: rtl/jbi_fc_pkg.sv
// jbi_fc_pkg: shared types, default watermarks and width helper for AOK/DOK flow control
package jbi_fc_pkg;

    typedef enum logic {FC_HOLD = 1'b0, FC_GRANT = 1'b1} fc_st_t;

    localparam int FC_A_DEPTH = 16;
    localparam int FC_A_HI    = 12;
    localparam int FC_A_LO    = 8;
    localparam int FC_D_DEPTH = 32;
    localparam int FC_D_HI    = 24;
    localparam int FC_D_LO    = 16;
    localparam int FC_HOLDOFF = 4;

    function automatic int fc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/jbi_fc_chan.sv
// jbi_fc_chan: one flow-control channel - occupancy counter, grant/hold FSM, holdoff timer, sticky error
module jbi_fc_chan
    import jbi_fc_pkg::*;
#(
    parameter int DEPTH   = FC_A_DEPTH,
    parameter int HI      = FC_A_HI,
    parameter int LO      = FC_A_LO,
    parameter int HOLDOFF = FC_HOLDOFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    output logic                       on,
    output logic                       off,
    output logic                       st,
    output logic [fc_cnt_w(DEPTH)-1:0] cnt,
    output logic                       err
);

    localparam int CW = fc_cnt_w(DEPTH);
    localparam int HW = fc_cnt_w(HOLDOFF);
    localparam logic [CW-1:0] MAX_C  = CW'(DEPTH);
    localparam logic [CW-1:0] HI_C   = CW'(HI);
    localparam logic [CW-1:0] LO_C   = CW'(LO);
    localparam logic [HW-1:0] HOLD_C = HW'(HOLDOFF - 1);

    generate
        if (!(LO < HI && HI <= DEPTH && HOLDOFF >= 1)) begin : g_bad_params
            $error("jbi_fc_chan: need LO < HI <= DEPTH and HOLDOFF >= 1");
        end
    endgenerate

    fc_st_t          state;
    logic [HW-1:0]   hold;
    logic            inc, dec, ovf, unf;
    logic [CW-1:0]   cnt_n;

    assign st = (state == FC_GRANT);

    // next occupancy, saturating at both ends, with the error conditions that saturation hides
    always_comb begin
        inc   = push & ~pop;
        dec   = pop & ~push;
        ovf   = inc && cnt == MAX_C;
        unf   = dec && cnt == '0;
        cnt_n = (inc && !ovf) ? cnt + 1'b1 : (dec && !unf) ? cnt - 1'b1 : cnt;
    end

    // withdraw immediately at HI; re-grant at LO only once the holdoff timer has drained
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            state <= FC_GRANT;
            on    <= 1'b0;
            off   <= 1'b0;
            hold  <= '0;
            err   <= 1'b0;
        end else begin
            cnt <= cnt_n;
            err <= err | ovf | unf;
            on  <= 1'b0;
            off <= 1'b0;
            if (state == FC_GRANT && cnt_n >= HI_C) begin
                state <= FC_HOLD;
                off   <= 1'b1;
                hold  <= HOLD_C;
            end else if (state == FC_HOLD && cnt_n <= LO_C && hold == '0) begin
                state <= FC_GRANT;
                on    <= 1'b1;
                hold  <= HOLD_C;
            end else if (hold != '0) begin
                hold <= hold - 1'b1;
            end
        end
    end

endmodule

// File: rtl/jbi_aok_dok_gen.sv
// jbi_aok_dok_gen: AOK/DOK on/off pulse generator for the address and data inbound queues
module jbi_aok_dok_gen
    import jbi_fc_pkg::*;
#(
    parameter int A_DEPTH = FC_A_DEPTH,
    parameter int A_HI    = FC_A_HI,
    parameter int A_LO    = FC_A_LO,
    parameter int D_DEPTH = FC_D_DEPTH,
    parameter int D_HI    = FC_D_HI,
    parameter int D_LO    = FC_D_LO,
    parameter int HOLDOFF = FC_HOLDOFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_push,
    input  logic                         a_pop,
    input  logic                         d_push,
    input  logic                         d_pop,
    output logic                         aok_on,
    output logic                         aok_off,
    output logic                         dok_on,
    output logic                         dok_off,
    output logic                         aok_st,
    output logic                         dok_st,
    output logic [fc_cnt_w(A_DEPTH)-1:0] a_cnt,
    output logic [fc_cnt_w(D_DEPTH)-1:0] d_cnt,
    output logic [1:0]                   fc_err
);

    logic a_err, d_err;

    assign fc_err = {d_err, a_err};

    jbi_fc_chan #(.DEPTH(A_DEPTH), .HI(A_HI), .LO(A_LO), .HOLDOFF(HOLDOFF)) u_addr (
        .clk (clk),
        .rst (rst),
        .push(a_push),
        .pop (a_pop),
        .on  (aok_on),
        .off (aok_off),
        .st  (aok_st),
        .cnt (a_cnt),
        .err (a_err)
    );

    jbi_fc_chan #(.DEPTH(D_DEPTH), .HI(D_HI), .LO(D_LO), .HOLDOFF(HOLDOFF)) u_data (
        .clk (clk),
        .rst (rst),
        .push(d_push),
        .pop (d_pop),
        .on  (dok_on),
        .off (dok_off),
        .st  (dok_st),
        .cnt (d_cnt),
        .err (d_err)
    );

endmodule

// File: tb/tb_jbi_aok_dok_gen.sv
// tb_jbi_aok_dok_gen: directed checks of the AOK/DOK generator, plus a HOLDOFF=6 copy to expose the holdoff delay
module tb_jbi_aok_dok_gen;

    logic       clk = 1'b0;
    logic       rst, a_push, a_pop, d_push, d_pop;
    logic       aok_on, aok_off, dok_on, dok_off, aok_st, dok_st;
    logic [4:0] a_cnt;
    logic [5:0] d_cnt;
    logic [1:0] fc_err;
    logic       h_aok_on, h_aok_off, h_dok_on, h_dok_off, h_aok_st, h_dok_st;
    logic [4:0] h_a_cnt;
    logic [5:0] h_d_cnt;
    logic [1:0] h_fc_err;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    jbi_aok_dok_gen dut (
        .clk(clk), .rst(rst), .a_push(a_push), .a_pop(a_pop), .d_push(d_push), .d_pop(d_pop),
        .aok_on(aok_on), .aok_off(aok_off), .dok_on(dok_on), .dok_off(dok_off),
        .aok_st(aok_st), .dok_st(dok_st), .a_cnt(a_cnt), .d_cnt(d_cnt), .fc_err(fc_err)
    );

    jbi_aok_dok_gen #(.HOLDOFF(6)) dut6 (
        .clk(clk), .rst(rst), .a_push(a_push), .a_pop(a_pop), .d_push(d_push), .d_pop(d_pop),
        .aok_on(h_aok_on), .aok_off(h_aok_off), .dok_on(h_dok_on), .dok_off(h_dok_off),
        .aok_st(h_aok_st), .dok_st(h_dok_st), .a_cnt(h_a_cnt), .d_cnt(h_d_cnt), .fc_err(h_fc_err)
    );

    task automatic step(input logic ap, input logic apo, input logic dp, input logic dpo);
        a_push = ap;
        a_pop  = apo;
        d_push = dp;
        d_pop  = dpo;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
        vectors++;
        if ({a_cnt, d_cnt, aok_st, dok_st, aok_on, aok_off, dok_on, dok_off, fc_err} !== {5'd0, 6'd0, 1'b1, 1'b1, 4'b0000, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_state: got cnt=%0d/%0d st=%b%b pulses=%b%b%b%b err=%b, want 0/0 st=11 pulses=0000 err=00",
                     a_cnt, d_cnt, aok_st, dok_st, aok_on, aok_off, dok_on, dok_off, fc_err);
        end
        step(0, 0, 0, 0);
        vectors++;
        if ({aok_on, aok_off, dok_on, dok_off, aok_st, dok_st} !== 6'b000011) begin
            miscompares++;
            $display("FAIL reset_exit: got pulses=%b%b%b%b st=%b%b, want 0000 st=11", aok_on, aok_off, dok_on, dok_off, aok_st, dok_st);
        end
    endtask

    task automatic test_addr_fill();
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0, 0);
            vectors++;
            if ({aok_on, aok_off, aok_st, a_cnt} !== {1'b0, i == 12, i != 12, 5'(i)}) begin
                miscompares++;
                $display("FAIL addr_fill[%0d]: got on=%b off=%b st=%b cnt=%0d, want on=0 off=%b st=%b cnt=%0d",
                         i, aok_on, aok_off, aok_st, a_cnt, i == 12, i != 12, i);
            end
            vectors++;
            if ({dok_on, dok_off, dok_st, d_cnt} !== {2'b00, 1'b1, 6'd0}) begin
                miscompares++;
                $display("FAIL dok_quiet[%0d]: got on=%b off=%b st=%b cnt=%0d, want 0 0 1 0", i, dok_on, dok_off, dok_st, d_cnt);
            end
        end
    endtask

    task automatic test_regrant();
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 0);
            vectors++;
            if ({aok_on, aok_off, aok_st, a_cnt} !== {i == 4, 1'b0, i == 4, 5'(12 - i)}) begin
                miscompares++;
                $display("FAIL regrant[%0d]: got on=%b off=%b st=%b cnt=%0d, want on=%b off=0 st=%b cnt=%0d",
                         i, aok_on, aok_off, aok_st, a_cnt, i == 4, i == 4, 12 - i);
            end
        end
    endtask

    task automatic test_holdoff();
        do_reset();
        for (int i = 0; i < 11; i++) step(1, 0, 0, 0);
        vectors++;
        if ({a_cnt, aok_st, h_aok_st, aok_off, h_aok_off} !== {5'd11, 1'b1, 1'b1, 2'b00}) begin
            miscompares++;
            $display("FAIL holdoff_pre: got cnt=%0d st=%b/%b off=%b/%b, want 11 st=1/1 off=0/0", a_cnt, aok_st, h_aok_st, aok_off, h_aok_off);
        end
        step(1, 0, 0, 0);
        vectors++;
        if ({a_cnt, aok_off, h_aok_off, aok_st, h_aok_st} !== {5'd12, 2'b11, 2'b00}) begin
            miscompares++;
            $display("FAIL holdoff_off: got cnt=%0d off=%b/%b st=%b/%b, want 12 off=1/1 st=0/0", a_cnt, aok_off, h_aok_off, aok_st, h_aok_st);
        end
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) step(0, 1, 0, 0);
            else step(0, 0, 0, 0);
            vectors++;
            if ({aok_on, h_aok_on, h_aok_st, a_cnt} !== {i == 4, i == 6, i == 6, 5'(i <= 4 ? 12 - i : 8)}) begin
                miscompares++;
                $display("FAIL holdoff[%0d]: got on=%b on6=%b st6=%b cnt=%0d, want on=%b on6=%b st6=%b cnt=%0d",
                         i, aok_on, h_aok_on, h_aok_st, a_cnt, i == 4, i == 6, i == 6, i <= 4 ? 12 - i : 8);
            end
        end
    endtask

    task automatic test_simul_watermark();
        do_reset();
        for (int i = 0; i < 24; i++) step(0, 0, 1, 0);
        vectors++;
        if ({d_cnt, dok_off, dok_st} !== {6'd24, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL data_hi: got cnt=%0d off=%b st=%b, want 24 1 0", d_cnt, dok_off, dok_st);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 1);
            vectors++;
            if ({d_cnt, dok_on, dok_off, dok_st, fc_err} !== {6'd24, 3'b000, 2'b00}) begin
                miscompares++;
                $display("FAIL data_pushpop[%0d]: got cnt=%0d on=%b off=%b st=%b err=%b, want 24 0 0 0 00",
                         i, d_cnt, dok_on, dok_off, dok_st, fc_err);
            end
        end
    endtask

    task automatic test_errors();
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
        vectors++;
        if ({a_cnt, fc_err} !== {5'd16, 2'b00}) begin
            miscompares++;
            $display("FAIL addr_full: got cnt=%0d err=%b, want 16 00", a_cnt, fc_err);
        end
        step(1, 0, 0, 0);
        vectors++;
        if ({a_cnt, fc_err} !== {5'd16, 2'b01}) begin
            miscompares++;
            $display("FAIL addr_ovf: got cnt=%0d err=%b, want 16 01", a_cnt, fc_err);
        end
        step(0, 0, 0, 1);
        vectors++;
        if ({d_cnt, fc_err} !== {6'd0, 2'b11}) begin
            miscompares++;
            $display("FAIL data_unf: got cnt=%0d err=%b, want 0 11", d_cnt, fc_err);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        vectors++;
        if ({a_cnt, fc_err} !== {5'd13, 2'b11}) begin
            miscompares++;
            $display("FAIL err_sticky: got cnt=%0d err=%b, want 13 11", a_cnt, fc_err);
        end
        do_reset();
        vectors++;
        if (fc_err !== 2'b00) begin
            miscompares++;
            $display("FAIL err_clear: got err=%b, want 00", fc_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 11; i++) step(1, 0, 1, 0);
        rst = 1'b1;
        step(1, 0, 1, 0);
        rst = 1'b0;
        vectors++;
        if ({a_cnt, d_cnt, aok_st, dok_st, aok_on, aok_off, dok_on, dok_off} !== {5'd0, 6'd0, 2'b11, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset_mid: got cnt=%0d/%0d st=%b%b pulses=%b%b%b%b, want 0/0 st=11 pulses=0000",
                     a_cnt, d_cnt, aok_st, dok_st, aok_on, aok_off, dok_on, dok_off);
        end
        step(0, 0, 0, 0);
        vectors++;
        if ({a_cnt, aok_on, aok_off, dok_on, dok_off} !== {5'd0, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset_mid_after: got cnt=%0d pulses=%b%b%b%b, want 0 0000", a_cnt, aok_on, aok_off, dok_on, dok_off);
        end
    endtask

    initial begin
        rst    = 1'b1;
        a_push = 1'b0;
        a_pop  = 1'b0;
        d_push = 1'b0;
        d_pop  = 1'b0;
        test_reset();
        test_addr_fill();
        test_regrant();
        test_holdoff();
        test_simul_watermark();
        test_errors();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
